// File: rtl/fifo_reader.sv
// Read-side controller for the on-chip FIFO: drains a commanded burst of words,
// hides the FIFO's one-cycle read latency in a 2-entry skid buffer, streams valid/ready.
module fifo_reader #(
  parameter int WIDTH     = 16,
  parameter int LEN_WIDTH = 9
) (
  input  logic                        fifo_reader_clk,
  input  logic                        fifo_reader_rst_n,
  input  logic                        cmd_start,
  input  logic [LEN_WIDTH-1:0]        cmd_len,
  output logic                        busy,
  output logic                        done,
  output logic                        fifo_re,
  input  logic                        fifo_empty,
  input  logic signed [WIDTH-1:0]     fifo_out,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic signed [WIDTH-1:0]     m_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic [LEN_WIDTH-1:0]      issued_q, issued_d;
  logic [LEN_WIDTH-1:0]      delivered_q, delivered_d;
  logic                      inflight_q, inflight_d;
  logic                      done_q, done_d;
  logic [1:0]                skid_cnt_q, skid_cnt_d;
  logic signed [WIDTH-1:0]   skid0_q, skid0_d;
  logic signed [WIDTH-1:0]   skid1_q, skid1_d;

  logic                      pop_s;
  logic [2:0]                occ_s;
  logic                      re_s;

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign m_valid = (skid_cnt_q != 2'd0);
  assign m_data  = skid0_q;
  assign fifo_re = re_s;

  // Issue decision: a read is only launched if its word is guaranteed a skid slot
  always_comb begin
    pop_s = 1'b0;
    occ_s = 3'd0;
    re_s  = 1'b0;
    pop_s = (skid_cnt_q != 2'd0) && m_ready;
    occ_s = {1'b0, skid_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    if (fifo_reader_rst_n && (state_q == ST_READ) && (issued_q < len_q) &&
        !fifo_empty && (occ_s < 3'd2)) begin
      re_s = 1'b1;
    end else begin
      re_s = 1'b0;
    end
  end

  // Burst sequencing and counters
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    done_d      = 1'b0;
    inflight_d  = re_s;
    issued_d    = re_s  ? issued_q + LEN_WIDTH'(1)    : issued_q;
    delivered_d = pop_s ? delivered_q + LEN_WIDTH'(1) : delivered_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          if (cmd_len != '0) begin
            state_d     = ST_READ;
            len_d       = cmd_len;
            issued_d    = '0;
            delivered_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (issued_d == len_q) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (delivered_d == len_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Skid buffer: entry 0 is the head; capture and pop may coincide
  always_comb begin
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    skid_cnt_d = skid_cnt_q;
    case ({inflight_q, pop_s})
      2'b10: begin
        case (skid_cnt_q)
          2'd0:    skid0_d = fifo_out;
          2'd1:    skid1_d = fifo_out;
          default: skid1_d = skid1_q;
        endcase
        skid_cnt_d = skid_cnt_q + 2'd1;
      end
      2'b01: begin
        skid0_d    = skid1_q;
        skid_cnt_d = skid_cnt_q - 2'd1;
      end
      2'b11: begin
        if (skid_cnt_q == 2'd1) begin
          skid0_d = fifo_out;
        end else begin
          skid0_d = skid1_q;
          skid1_d = fifo_out;
        end
      end
      default: begin
        skid_cnt_d = skid_cnt_q;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge fifo_reader_clk) begin
    if (!fifo_reader_rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      skid_cnt_q  <= 2'd0;
      skid0_q     <= '0;
      skid1_q     <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      inflight_q  <= inflight_d;
      done_q      <= done_d;
      skid_cnt_q  <= skid_cnt_d;
      skid0_q     <= skid0_d;
      skid1_q     <= skid1_d;
    end
  end

endmodule
